// File: rtl/and4_x4_pkg.sv
// Shared constants for the four-input AND cell family.
package and4_x4_pkg;

  localparam int unsigned WIDTH_DEFAULT = 1;
  localparam int unsigned WIDTH_MAX     = 64;

  function automatic bit widthOk(input int unsigned w);
    return (w >= 1) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/and4_x4_core.sv
// Purely combinational WIDTH-bit four-input AND, the standard-cell ZN function.
module and4_x4_core
  import and4_x4_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  output logic [WIDTH-1:0] zn
);

  assign zn = a1 & a2 & a3 & a4;

endmodule

// File: rtl/and4_x4_cell.sv
// Four-input AND cell with zero-latency output plus a valid-qualified capture register.
// Defining AND4_X4_SELFCHECK_EN adds a sticky De Morgan cross-check on output chk_err.
module and4_x4_cell
  import and4_x4_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic             in_valid,
  output logic [WIDTH-1:0] zn,
  output logic [WIDTH-1:0] zn_q,
  output logic             out_valid,
  output logic             all_ones
`ifdef AND4_X4_SELFCHECK_EN
  ,
  output logic             chk_err
`endif
);

  if (!widthOk(WIDTH)) begin : gWidthCheck
    $error("and4_x4_cell: WIDTH must lie in 1..WIDTH_MAX");
  end

  logic [WIDTH-1:0] znCore;
  logic [WIDTH-1:0] captured_q, captured_d;
  logic             validPipe_q, validPipe_d;

  and4_x4_core #(.WIDTH(WIDTH)) uCore (
    .a1 (a1),
    .a2 (a2),
    .a3 (a3),
    .a4 (a4),
    .zn (znCore)
  );

  always_comb begin
    captured_d  = captured_q;
    validPipe_d = in_valid;
    if (in_valid) begin
      captured_d = znCore;
    end
  end

  // Reset clears the registered side at once; zn stays purely combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured_q  <= '0;
      validPipe_q <= 1'b0;
    end else begin
      captured_q  <= captured_d;
      validPipe_q <= validPipe_d;
    end
  end

  assign zn        = znCore;
  assign zn_q      = captured_q;
  assign out_valid = validPipe_q;
  assign all_ones  = &captured_q;

`ifdef AND4_X4_SELFCHECK_EN
  logic [WIDTH-1:0] deMorgan;
  logic             chkErr_q, chkErr_d;

  // Independent OR-of-inverses form so a fault in the core cannot hide itself.
  assign deMorgan = ~(~a1 | ~a2 | ~a3 | ~a4);

  always_comb begin
    chkErr_d = chkErr_q;
    if (in_valid && (|(deMorgan ^ znCore))) begin
      chkErr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chkErr_q <= 1'b0;
    end else begin
      chkErr_q <= chkErr_d;
    end
  end

  assign chk_err = chkErr_q;
`endif

endmodule

// File: tb/tb_and4_x4_cell.sv
// Scoreboard bench for and4_x4_cell: a WIDTH=8 and a WIDTH=1 instance share clock and reset.
module tb_and4_x4_cell;

  typedef struct {
    logic [7:0] q8;
    logic       v8;
    logic       all8;
    logic       q1;
    logic       v1;
    logic       all1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a1, a2, a3, a4;
  logic       inValid8;
  logic       b1, b2, b3, b4;
  logic       inValid1;
  logic [7:0] zn8, znQ8;
  logic       outValid8, allOnes8;
  logic       zn1, znQ1;
  logic       outValid1, allOnes1;
`ifdef AND4_X4_SELFCHECK_EN
  logic       chkErr8, chkErr1;
`endif

  int   checks   = 0;
  int   failures = 0;
  bit   monitorOn = 1'b1;
  exp_t sbQ[$];
  logic [7:0] model8;
  logic       model1;

  always #5 clk = ~clk;

  and4_x4_cell #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .a4        (a4),
    .in_valid  (inValid8),
    .zn        (zn8),
    .zn_q      (znQ8),
    .out_valid (outValid8),
    .all_ones  (allOnes8)
`ifdef AND4_X4_SELFCHECK_EN
    ,
    .chk_err   (chkErr8)
`endif
  );

  and4_x4_cell #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a1        (b1),
    .a2        (b2),
    .a3        (b3),
    .a4        (b4),
    .in_valid  (inValid1),
    .zn        (zn1),
    .zn_q      (znQ1),
    .out_valid (outValid1),
    .all_ones  (allOnes1)
`ifdef AND4_X4_SELFCHECK_EN
    ,
    .chk_err   (chkErr1)
`endif
  );

  // Reference: a bit is set only when all four operands contribute a one.
  function automatic logic [7:0] andModel8(input logic [7:0] x1, input logic [7:0] x2,
                                           input logic [7:0] x3, input logic [7:0] x4);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      int s;
      s = int'(x1[i]) + int'(x2[i]) + int'(x3[i]) + int'(x4[i]);
      r[i] = (s == 4);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, want);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] x1, input logic [7:0] x2,
                               input logic [7:0] x3, input logic [7:0] x4,
                               input logic v8, input logic [3:0] p, input logic v1);
    exp_t e;
    @(negedge clk);
    a1 = x1; a2 = x2; a3 = x3; a4 = x4; inValid8 = v8;
    {b1, b2, b3, b4} = p; inValid1 = v1;
    #1;
    checkOutput("zn8", 64'(zn8), 64'(andModel8(x1, x2, x3, x4)));
    checkOutput("zn1", 64'(zn1), 64'(p == 4'b1111));
    if (v8) model8 = andModel8(x1, x2, x3, x4);
    if (v1) model1 = (p == 4'b1111);
    e.q8 = model8; e.v8 = v8; e.all8 = (model8 == 8'hFF);
    e.q1 = model1; e.v1 = v1; e.all1 = model1;
    sbQ.push_back(e);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_znq8"}, 64'(znQ8), 64'd0);
    checkOutput({tag, "_ov8"}, 64'(outValid8), 64'd0);
    checkOutput({tag, "_all8"}, 64'(allOnes8), 64'd0);
    checkOutput({tag, "_znq1"}, 64'(znQ1), 64'd0);
    checkOutput({tag, "_ov1"}, 64'(outValid1), 64'd0);
    checkOutput({tag, "_all1"}, 64'(allOnes1), 64'd0);
  endtask

  // Asserts reset between edges and checks the registered side clears before any edge.
  task automatic midReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("midrst");
    a1 = 8'h5A; a2 = 8'hFF; a3 = 8'h7E; a4 = 8'hF3;
    {b1, b2, b3, b4} = 4'b1111;
    inValid8 = 1'b0; inValid1 = 1'b0;
    #1;
    checkOutput("midrst_zn8", 64'(zn8), 64'(andModel8(8'h5A, 8'hFF, 8'h7E, 8'hF3)));
    checkOutput("midrst_zn1", 64'(zn1), 64'd1);
    @(negedge clk);
    model8 = 8'h00;
    model1 = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: one expected entry per active edge while stimulus is flowing.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (monitorOn && sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("znq8", 64'(znQ8), 64'(e.q8));
      checkOutput("outvalid8", 64'(outValid8), 64'(e.v8));
      checkOutput("allones8", 64'(allOnes8), 64'(e.all8));
      checkOutput("znq1", 64'(znQ1), 64'(e.q1));
      checkOutput("outvalid1", 64'(outValid1), 64'(e.v1));
      checkOutput("allones1", 64'(allOnes1), 64'(e.all1));
`ifdef AND4_X4_SELFCHECK_EN
      checkOutput("chkerr8", 64'(chkErr8), 64'd0);
      checkOutput("chkerr1", 64'(chkErr1), 64'd0);
`endif
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; a4 = '0; inValid8 = 1'b0;
    {b1, b2, b3, b4} = 4'b0000; inValid1 = 1'b0;
    model8 = '0; model1 = 1'b0;
    #3;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int p = 0; p < 16; p++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom), 4'(p), 1'b0);
    end

    applyStimulus(8'hFF, 8'hF0, 8'h3C, 8'hAA, 1'b1, 4'b1111, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 4'b0111, 1'b0);
    applyStimulus(8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 4'b0000, 1'b0);

    applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 4'b1111, 1'b1);
    midReset();

    applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 4'b1111, 1'b1);
    applyStimulus(8'hF0, 8'hFF, 8'h0F, 8'hFF, 1'b1, 4'b1110, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 4'b1111, 1'b1);
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 4'b0000, 1'b1);

    for (int n = 0; n < 150; n++) begin
      logic [7:0] r [4];
      for (int k = 0; k < 4; k++) begin
        r[k] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      end
      applyStimulus(r[0], r[1], r[2], r[3], 1'($urandom),
                    ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom), 1'($urandom));
    end

    guard = 0;
    while (sbQ.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checkOutput("drain", 64'(sbQ.size()), 64'd0);
    monitorOn = 1'b0;

`ifdef AND4_X4_SELFCHECK_EN
    @(negedge clk);
    {b1, b2, b3, b4} = 4'b1111; inValid1 = 1'b1;
    force dut1.znCore = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("chk_set", 64'(chkErr1), 64'd1);
    @(negedge clk);
    release dut1.znCore;
    inValid1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("chk_sticky", 64'(chkErr1), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("chk_reset", 64'(chkErr1), 64'd0);
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
